// File: rtl/mips_pipe_control.sv
// mips_pipe_control: decodes the ID-stage opcode into per-stage control
// bundles and carries them through the ID/EX, EX/MEM and MEM/WB registers.
// It also detects load-use hazards (one-cycle stall) and sequences the squash
// of younger instructions after a taken branch or jump resolved in EX.
module mips_pipe_control #(
    parameter int REG_AW         = 5,
    parameter int FLUSH_SLOTS    = 1,
    parameter int LOAD_USE_STALL = 1,
    parameter int LINK_REG       = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [5:0]        id_op,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output logic              pc_hold,
    output logic              id_squash,
    output logic [3:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic              ex_isjump,
    output logic              ex_isuncond,
    output logic              ex_iseq,
    output logic              mem_write,
    output logic              mem_read,
    output logic [1:0]        mem_size,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_AW-1:0] wb_dest,
    output logic [1:0]        busy_state
);

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       isjump;
        logic       isuncond;
        logic       iseq;
    } ex_ctrl_t;

    typedef struct packed {
        logic       write;
        logic       read;
        logic [1:0] size;
    } mem_ctrl_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] dest;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } idex_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } exmem_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [REG_AW-1:0] LINK_ADDR = REG_AW'(LINK_REG);
    localparam logic [REG_AW-1:0] ZERO_REG  = {REG_AW{1'b0}};
    // The redirect cycle squashes one slot itself, so FLUSH covers the rest;
    // the counter holds the number of FLUSH cycles left after the current one.
    localparam logic [1:0] FLUSH_CNT_INIT =
        (FLUSH_SLOTS > 32'sd1) ? 2'(FLUSH_SLOTS - 32'sd2) : 2'd0;
    localparam idex_t    IDEX_BUBBLE  = idex_t'({$bits(idex_t){1'b0}});
    localparam exmem_t   EXMEM_BUBBLE = exmem_t'({$bits(exmem_t){1'b0}});
    localparam wb_ctrl_t WB_BUBBLE    = wb_ctrl_t'({$bits(wb_ctrl_t){1'b0}});

    idex_t    dec_s;
    idex_t    idex_r;
    exmem_t   exmem_r;
    wb_ctrl_t memwb_r;
    state_t   state_r;
    logic [1:0] cnt_r;

    logic is_load_s;
    logic is_store_s;
    logic is_branch_s;
    logic hazard_s;
    logic id_squash_s;
    logic pc_hold_s;
    logic bubble_s;

    assign is_load_s   = (id_op[5:3] == 3'b100);
    assign is_store_s  = (id_op[5:3] == 3'b101);
    assign is_branch_s = (id_op >= 6'd2) && (id_op <= 6'd5);

    // Combinational opcode decode of the instruction sitting in IF/ID.
    always_comb begin
        dec_s = IDEX_BUBBLE;
        if (id_op[5]) begin
            dec_s.ex.aluop = 4'd0;
        end else if (is_branch_s) begin
            dec_s.ex.aluop = 4'd1;
        end else if (id_op == 6'd0) begin
            dec_s.ex.aluop = 4'd2;
        end else begin
            dec_s.ex.aluop = id_op[3:0];
        end
        dec_s.ex.alusrc   = id_op[5] | id_op[3];
        dec_s.ex.isjump   = is_branch_s;
        dec_s.ex.isuncond = ~id_op[2];
        dec_s.ex.iseq     = ~id_op[0];
        dec_s.mem.write   = is_store_s;
        dec_s.mem.read    = is_load_s;
        if (is_load_s | is_store_s) begin
            dec_s.mem.size = id_op[1:0];
        end else begin
            dec_s.mem.size = 2'b11;
        end
        dec_s.wb.regwrite = ~(is_store_s | (id_op == 6'd2) | (id_op == 6'd4) | (id_op == 6'd5));
        dec_s.wb.memtoreg = is_load_s | (id_op == 6'h0F);
        if (id_op == 6'd0) begin
            dec_s.wb.dest = id_rd;
        end else if (id_op == 6'd3) begin
            dec_s.wb.dest = LINK_ADDR;
        end else begin
            dec_s.wb.dest = id_rt;
        end
    end

    // A load in EX whose nonzero destination feeds the ID instruction needs one bubble.
    assign hazard_s = (LOAD_USE_STALL != 32'sd0) && idex_r.mem.read &&
                      (idex_r.wb.dest != ZERO_REG) &&
                      ((idex_r.wb.dest == id_rs) || (idex_r.wb.dest == id_rt));

    // Squash wins over a stall: a squashed instruction cannot hold the front end.
    assign id_squash_s = rst_n & (ex_redirect | (state_r == ST_FLUSH));
    assign pc_hold_s   = rst_n & hazard_s & ~id_squash_s;
    assign bubble_s    = ~id_valid | id_squash_s | pc_hold_s;

    // Control pipeline: ID/EX takes the decode or a bubble, later stages always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_r  <= IDEX_BUBBLE;
            exmem_r <= EXMEM_BUBBLE;
            memwb_r <= WB_BUBBLE;
        end else begin
            if (bubble_s) begin
                idex_r <= IDEX_BUBBLE;
            end else begin
                idex_r <= dec_s;
            end
            exmem_r <= '{mem: idex_r.mem, wb: idex_r.wb};
            memwb_r <= exmem_r.wb;
        end
    end

    // Hazard/flush sequencer; a redirect in any state (re)starts the flush window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
        end else if (ex_redirect) begin
            if (FLUSH_SLOTS > 32'sd1) begin
                state_r <= ST_FLUSH;
                cnt_r   <= FLUSH_CNT_INIT;
            end else begin
                state_r <= ST_RUN;
                cnt_r   <= 2'd0;
            end
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pc_hold_s) begin
                        state_r <= ST_STALL;
                    end else begin
                        state_r <= ST_RUN;
                    end
                    cnt_r <= 2'd0;
                end
                ST_STALL: begin
                    // The load has moved on to EX/MEM, so no repeat hazard is possible.
                    state_r <= ST_RUN;
                    cnt_r   <= 2'd0;
                end
                ST_FLUSH: begin
                    if (cnt_r == 2'd0) begin
                        state_r <= ST_RUN;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

    assign pc_hold     = pc_hold_s;
    assign id_squash   = id_squash_s;
    assign ex_aluop    = idex_r.ex.aluop;
    assign ex_alusrc   = idex_r.ex.alusrc;
    assign ex_isjump   = idex_r.ex.isjump;
    assign ex_isuncond = idex_r.ex.isuncond;
    assign ex_iseq     = idex_r.ex.iseq;
    assign mem_write   = exmem_r.mem.write;
    assign mem_read    = exmem_r.mem.read;
    assign mem_size    = exmem_r.mem.size;
    assign wb_regwrite = memwb_r.regwrite;
    assign wb_memtoreg = memwb_r.memtoreg;
    assign wb_dest     = memwb_r.dest;
    assign busy_state  = state_r;

endmodule

// File: tb/tb_mips_pipe_control.sv
// Bench for mips_pipe_control: two instances (FLUSH_SLOTS=2 with stalls,
// FLUSH_SLOTS=1 forwarding-only) share one directed stimulus stream. A
// stage-array model predicts every output each cycle; literal expectations
// pin the key scenarios.
module tb_mips_pipe_control;
    localparam int AW   = 5;
    localparam int FS0  = 2;
    localparam int FS1  = 1;
    localparam int LUS0 = 1;
    localparam int LUS1 = 0;
    localparam int LINK = 31;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, id_valid, ex_redirect;
    logic [5:0]    id_op;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic [1:0]    pc_hold, id_squash, ex_alusrc, ex_isjump, ex_isuncond, ex_iseq;
    logic [1:0]    mem_write, mem_read, wb_regwrite, wb_memtoreg;
    logic [1:0][3:0]    ex_aluop;
    logic [1:0][1:0]    mem_size, busy_state;
    logic [1:0][AW-1:0] wb_dest;

    mips_pipe_control #(.REG_AW(AW), .FLUSH_SLOTS(FS0), .LOAD_USE_STALL(LUS0), .LINK_REG(LINK)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_redirect(ex_redirect), .pc_hold(pc_hold[0]), .id_squash(id_squash[0]),
        .ex_aluop(ex_aluop[0]), .ex_alusrc(ex_alusrc[0]), .ex_isjump(ex_isjump[0]),
        .ex_isuncond(ex_isuncond[0]), .ex_iseq(ex_iseq[0]), .mem_write(mem_write[0]),
        .mem_read(mem_read[0]), .mem_size(mem_size[0]), .wb_regwrite(wb_regwrite[0]),
        .wb_memtoreg(wb_memtoreg[0]), .wb_dest(wb_dest[0]), .busy_state(busy_state[0]));

    mips_pipe_control #(.REG_AW(AW), .FLUSH_SLOTS(FS1), .LOAD_USE_STALL(LUS1), .LINK_REG(LINK)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .ex_redirect(ex_redirect), .pc_hold(pc_hold[1]), .id_squash(id_squash[1]),
        .ex_aluop(ex_aluop[1]), .ex_alusrc(ex_alusrc[1]), .ex_isjump(ex_isjump[1]),
        .ex_isuncond(ex_isuncond[1]), .ex_iseq(ex_iseq[1]), .mem_write(mem_write[1]),
        .mem_read(mem_read[1]), .mem_size(mem_size[1]), .wb_regwrite(wb_regwrite[1]),
        .wb_memtoreg(wb_memtoreg[1]), .wb_dest(wb_dest[1]), .busy_state(busy_state[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: one control bundle per stage (EX, MEM, WB) per instance.
    typedef struct packed {
        bit rw, m2r, mr, mw, jmp, unc, eq, src;
        int alu, size, dest;
    } ctl_t;
    localparam ctl_t BUB = '0;

    ctl_t pipe [2][3];
    int   left [2];      // squash slots still pending after the current cycle
    bit   stalled_prev [2];

    function automatic ctl_t mdec(input int op, input int rt, input int rd);
        ctl_t c;
        bit ld, st;
        c = BUB;
        ld = (op >= 32) && (op < 40);
        st = (op >= 40) && (op < 48);
        c.mr = ld;
        c.mw = st;
        c.size = (ld || st) ? op % 4 : 3;
        if (op >= 32) c.alu = 0;
        else if (op >= 2 && op <= 5) c.alu = 1;
        else if (op == 0) c.alu = 2;
        else c.alu = op % 16;
        c.jmp = (op >= 2) && (op <= 5);
        c.unc = ((op / 4) % 2) == 0;
        c.eq  = (op % 2) == 0;
        c.src = (op >= 32) || (((op / 8) % 2) == 1);
        c.rw  = !(st || op == 2 || op == 4 || op == 5);
        c.m2r = ld || (op == 15);
        c.dest = (op == 0) ? rd : ((op == 3) ? LINK : rt);
        return c;
    endfunction

    task automatic model_cycle(input int i);
        ctl_t ex, mm, wb, nx;
        int fs, lus, busy;
        bit sq, hz, hold;
        string p;
        fs  = (i == 0) ? FS0 : FS1;
        lus = (i == 0) ? LUS0 : LUS1;
        p = $sformatf("u%0d.", i);
        if (rst_n !== 1'b1) begin
            for (int s = 0; s < 3; s++) pipe[i][s] = BUB;
            left[i] = 0;
            stalled_prev[i] = 1'b0;
        end
        ex = pipe[i][0];
        mm = pipe[i][1];
        wb = pipe[i][2];
        sq = (rst_n === 1'b1) && ((ex_redirect === 1'b1) || (left[i] > 0));
        hz = (lus != 0) && ex.mr && (ex.dest != 0) && (ex.dest == int'(id_rs) || ex.dest == int'(id_rt));
        hold = hz && !sq;
        busy = (left[i] > 0) ? 2 : (stalled_prev[i] ? 1 : 0);
        chk({p, "pc_hold"},     32'(pc_hold[i]),     32'(hold));
        chk({p, "id_squash"},   32'(id_squash[i]),   32'(sq));
        chk({p, "busy_state"},  32'(busy_state[i]),  32'(busy));
        chk({p, "ex_aluop"},    32'(ex_aluop[i]),    32'(ex.alu));
        chk({p, "ex_alusrc"},   32'(ex_alusrc[i]),   32'(ex.src));
        chk({p, "ex_isjump"},   32'(ex_isjump[i]),   32'(ex.jmp));
        chk({p, "ex_isuncond"}, 32'(ex_isuncond[i]), 32'(ex.unc));
        chk({p, "ex_iseq"},     32'(ex_iseq[i]),     32'(ex.eq));
        chk({p, "mem_write"},   32'(mem_write[i]),   32'(mm.mw));
        chk({p, "mem_read"},    32'(mem_read[i]),    32'(mm.mr));
        chk({p, "mem_size"},    32'(mem_size[i]),    32'(mm.size));
        chk({p, "wb_regwrite"}, 32'(wb_regwrite[i]), 32'(wb.rw));
        chk({p, "wb_memtoreg"}, 32'(wb_memtoreg[i]), 32'(wb.m2r));
        chk({p, "wb_dest"},     32'(wb_dest[i]),     32'(wb.dest));
        if (rst_n === 1'b1) begin
            if (id_valid !== 1'b1 || sq || hold) nx = BUB;
            else nx = mdec(int'(id_op), int'(id_rt), int'(id_rd));
            pipe[i][2] = pipe[i][1];
            pipe[i][1] = pipe[i][0];
            pipe[i][0] = nx;
            if (ex_redirect === 1'b1) left[i] = fs - 1;
            else if (left[i] > 0) left[i] = left[i] - 1;
            else left[i] = 0;
            stalled_prev[i] = hold;
        end
    endtask

    // Compare process: every falling edge, both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) model_cycle(i);
        end
    end

    task automatic cyc(input bit v, input int op, input int rs, input int rt, input int rd, input bit redir);
        @(posedge clk);
        #1;
        id_valid = v;
        id_op = 6'(op);
        id_rs = AW'(rs);
        id_rt = AW'(rt);
        id_rd = AW'(rd);
        ex_redirect = redir;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int ops [8] = '{'h0F, 'h04, 'h05, 'h08, 'h21, 'h28, 'h02, 'h0C};

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_op = 6'd0;
        id_rs = '0; id_rt = '0; id_rd = '0; ex_redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(busy_state[0]), 32'd0);
        chk("rst.mem_size", 32'(mem_size[0]), 32'd0);
        release_rst();

        // R-type, rd=9
        cyc(1'b1, 0, 1, 2, 9, 1'b0);
        idle(1);
        chk("rtype.ex_aluop", 32'(ex_aluop[0]), 32'd2);
        idle(2);
        chk("rtype.wb_regwrite", 32'(wb_regwrite[0]), 32'd1);
        chk("rtype.wb_dest", 32'(wb_dest[0]), 32'd9);
        chk("rtype.wb_memtoreg", 32'(wb_memtoreg[0]), 32'd0);

        // Load rt=4 then use of r4: one stall on u0, none on u1
        cyc(1'b1, 'h23, 1, 4, 0, 1'b0);
        cyc(1'b1, 0, 4, 5, 7, 1'b0);
        chk("lu.hold0", 32'(pc_hold[0]), 32'd1);
        chk("lu.busy0", 32'(busy_state[0]), 32'd0);
        chk("lu.hold1", 32'(pc_hold[1]), 32'd0);
        cyc(1'b1, 0, 4, 5, 7, 1'b0);
        chk("lu.hold0b", 32'(pc_hold[0]), 32'd0);
        chk("lu.busy0b", 32'(busy_state[0]), 32'd1);
        chk("lu.bubble", 32'(ex_aluop[0]), 32'd0);
        chk("lu.memrd", 32'(mem_read[0]), 32'd1);
        chk("lu.u1ex", 32'(ex_aluop[1]), 32'd2);
        idle(1);
        chk("lu.busy0c", 32'(busy_state[0]), 32'd0);
        chk("lu.reissue", 32'(ex_aluop[0]), 32'd2);
        idle(2);

        // Load into r0: never a hazard
        cyc(1'b1, 'h23, 1, 0, 0, 1'b0);
        cyc(1'b1, 0, 0, 5, 7, 1'b0);
        chk("lu0.hold", 32'(pc_hold[0]), 32'd0);
        idle(3);

        // JAL then store
        cyc(1'b1, 3, 0, 0, 0, 1'b0);
        cyc(1'b1, 'h2B, 2, 3, 0, 1'b0);
        chk("jal.isjump", 32'(ex_isjump[0]), 32'd1);
        chk("jal.isuncond", 32'(ex_isuncond[0]), 32'd1);
        idle(1);
        idle(1);
        chk("jal.wb_dest", 32'(wb_dest[0]), 32'd31);
        chk("jal.wb_regwrite", 32'(wb_regwrite[0]), 32'd1);
        chk("sw.mem_write", 32'(mem_write[0]), 32'd1);
        chk("sw.mem_size", 32'(mem_size[0]), 32'd3);
        idle(1);
        chk("sw.wb_regwrite", 32'(wb_regwrite[0]), 32'd0);
        idle(1);

        // Assorted opcodes, model-checked
        for (int k = 0; k < 8; k++) cyc(1'b1, ops[k], k + 10, k + 20, k + 1, 1'b0);
        idle(3);

        // Single redirect pulse
        cyc(1'b1, 0, 1, 2, 3, 1'b1);
        chk("rd.sq0", 32'(id_squash[0]), 32'd1);
        chk("rd.sq1", 32'(id_squash[1]), 32'd1);
        chk("rd.busy0", 32'(busy_state[0]), 32'd0);
        cyc(1'b1, 0, 1, 2, 3, 1'b0);
        chk("rd.sq0b", 32'(id_squash[0]), 32'd1);
        chk("rd.busy0b", 32'(busy_state[0]), 32'd2);
        chk("rd.sq1b", 32'(id_squash[1]), 32'd0);
        chk("rd.bubble", 32'(ex_aluop[0]), 32'd0);
        cyc(1'b1, 0, 1, 2, 3, 1'b0);
        chk("rd.sq0c", 32'(id_squash[0]), 32'd0);
        chk("rd.busy0c", 32'(busy_state[0]), 32'd0);

        // Second pulse inside FLUSH restarts the window
        cyc(1'b0, 0, 0, 0, 0, 1'b1);
        cyc(1'b0, 0, 0, 0, 0, 1'b1);
        chk("rd2.busy", 32'(busy_state[0]), 32'd2);
        idle(1);
        chk("rd2.sq_ext", 32'(id_squash[0]), 32'd1);
        chk("rd2.busy_ext", 32'(busy_state[0]), 32'd2);
        idle(1);
        chk("rd2.sq_end", 32'(id_squash[0]), 32'd0);
        chk("rd2.busy_end", 32'(busy_state[0]), 32'd0);

        // Redirect coinciding with a load-use hazard
        cyc(1'b1, 'h23, 1, 6, 0, 1'b0);
        cyc(1'b1, 0, 6, 0, 3, 1'b1);
        chk("rdh.hold", 32'(pc_hold[0]), 32'd0);
        chk("rdh.sq", 32'(id_squash[0]), 32'd1);
        idle(1);
        chk("rdh.busy", 32'(busy_state[0]), 32'd2);
        idle(3);

        // Asynchronous reset with a load in MEM
        cyc(1'b1, 'h23, 1, 4, 0, 1'b0);
        idle(2);
        chk("mr.pre_memrd", 32'(mem_read[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr.memrd", 32'(mem_read[0]), 32'd0);
        chk("mr.busy", 32'(busy_state[0]), 32'd0);
        for (int i = 0; i < 2; i++)
            chk($sformatf("mr.all%0d", i),
                32'({pc_hold[i], id_squash[i], ex_aluop[i], ex_alusrc[i], ex_isjump[i], ex_isuncond[i],
                     ex_iseq[i], mem_write[i], mem_read[i], mem_size[i], wb_regwrite[i], wb_memtoreg[i],
                     wb_dest[i], busy_state[i]}), 32'd0);
        idle(1);
        release_rst();
        cyc(1'b1, 0, 1, 2, 9, 1'b0);
        idle(3);
        chk("post.wb_dest", 32'(wb_dest[0]), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
